// File: rtl/spiker_seq_pkg.sv
// Shared state encoding and default widths for the spiker step sequencer.
package spiker_seq_pkg;

  localparam int DEF_STEP_W = 16;
  localparam int DEF_TMO_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CORE,
    CAPTURE,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/spiker_step_watchdog.sv
// Per-step watchdog: down-counter loaded with the limit at step issue,
// terminal count at 1 flags the limit-th waiting cycle; a limit of 0 never expires.
module spiker_step_watchdog
  import spiker_seq_pkg::*;
#(
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] remain;

  always_ff @(posedge clk) begin
    if (rst) begin
      remain <= '0;
    end else if (load) begin
      remain <= limit;
    end else if (enable && (remain != '0)) begin
      remain <= remain - TMO_W'(1);
    end
  end

  // Parks at 0 after the terminal count, so expire fires at most once per load.
  assign expire = enable && (remain == TMO_W'(1));

endmodule

// File: rtl/spiker_step_sequencer.sv
// Runs a multi-timestep inference: one core step request per timestep,
// a writer sample pulse after each step, and busy/done/timeout status.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no run; start accepted here only
// ISSUE     | step pending, stalled on writer_ready_i
// WAIT_CORE | step request sent, waiting for core_ready_i, watchdog live
// CAPTURE   | sample pulse to writer, decide next step or finish
// FINISH    | done pulse, back to IDLE
module spiker_step_sequencer
  import spiker_seq_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int TMO_W  = DEF_TMO_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] n_steps_i,
  input  logic [TMO_W-1:0]  timeout_cycles_i,
  input  logic              writer_ready_i,
  output logic              core_valid_o,
  input  logic              core_ready_i,
  output logic              sample_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [STEP_W-1:0] step_count_o
);

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] n_steps_q, n_steps_d;
  logic [STEP_W-1:0] step_count_d;
  logic              core_valid_d, sample_d, busy_d, done_d, timeout_d;
  logic              accept_start, issue, wd_expire;

  assign accept_start = (state_q == IDLE) && start_i && !abort_i;

  spiker_step_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (issue),
    .enable (state_q == WAIT_CORE),
    .limit  (timeout_cycles_i),
    .expire (wd_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      n_steps_q    <= '0;
      step_count_o <= '0;
      core_valid_o <= 1'b0;
      sample_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_steps_q    <= n_steps_d;
      step_count_o <= step_count_d;
      core_valid_o <= core_valid_d;
      sample_o     <= sample_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      timeout_o    <= timeout_d;
    end
  end

  // Issue decisions look at writer_ready_i in the deciding cycle so the
  // registered core_valid_o appears one cycle after a start or capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i && (n_steps_i != '0)) begin
          state_d = writer_ready_i ? WAIT_CORE : ISSUE;
        end
      end
      ISSUE: begin
        if (writer_ready_i) state_d = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_ready_i)   state_d = CAPTURE;
        else if (wd_expire) state_d = FINISH;
      end
      CAPTURE: begin
        if (step_count_o == n_steps_q) state_d = FINISH;
        else                           state_d = writer_ready_i ? WAIT_CORE : ISSUE;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_comb begin
    issue        = (state_d == WAIT_CORE) && (state_q != WAIT_CORE);
    core_valid_d = issue;
    sample_d     = (state_d == CAPTURE);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FINISH) || (accept_start && (n_steps_i == '0));
    n_steps_d    = n_steps_q;
    step_count_d = step_count_o;
    timeout_d    = timeout_o;
    // A zero-step start clears timeout but keeps the previous step count.
    if (accept_start) begin
      timeout_d = 1'b0;
      if (n_steps_i != '0) begin
        n_steps_d    = n_steps_i;
        step_count_d = '0;
      end
    end
    if (state_d == CAPTURE) step_count_d = step_count_o + STEP_W'(1);
    if ((state_q == WAIT_CORE) && wd_expire && !core_ready_i && !abort_i) timeout_d = 1'b1;
  end

endmodule

// File: doc/spiker_step_sequencer.md
Name: spiker_step_sequencer

Overview:
Controller that runs one multi-timestep inference on the spiker core and feeds results to the spike-result writer. On a start command it issues one step request per timestep and waits for the core's ready pulse. After each step it pulses sample to the writer so the result registers are refreshed. It sits between the register-file control fields (start/abort/n_steps/timeout) and the core/writer pair, and reports busy/done/timeout back to the status registers.

Parameters:
STEP_W, 16, width of timestep count and step counter
TMO_W, 16, width of per-step watchdog counter

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  single-cycle start command from register file
abort_i  in  1  single-cycle abort command
n_steps_i  in  STEP_W  timesteps to run, sampled when start_i is accepted
timeout_cycles_i  in  TMO_W  per-step watchdog limit; 0 disables the watchdog
writer_ready_i  in  1  writer pipeline free
core_valid_o  out  1  one-cycle step request to the spiker core
core_ready_i  in  1  core step-complete pulse (the writer captures data on the same edge)
sample_o  out  1  one-cycle pulse to the writer to copy the captured data into the result registers
busy_o  out  1  run in progress
done_o  out  1  one-cycle completion pulse
timeout_o  out  1  sticky watchdog flag
step_count_o  out  STEP_W  completed steps in the current or last run

Behaviour:
- Reset values: core_valid_o=0, sample_o=0, busy_o=0, done_o=0, timeout_o=0, step_count_o=0, state=IDLE. Reset is synchronous, active-high.
- States: IDLE, ISSUE, WAIT_CORE, CAPTURE, FINISH.
- IDLE:
  - start_i with n_steps_i!=0: latch n_steps_i, step_count_o<=0, timeout_o<=0, go to ISSUE.
  - start_i with n_steps_i==0: done_o pulses in the next cycle, state stays IDLE, timeout_o is cleared.
- ISSUE:
  - Wait for writer_ready_i=1.
  - Then drive core_valid_o=1 for exactly one cycle, clear the watchdog, go to WAIT_CORE.
  - Minimum latency: start_i accepted in cycle T gives core_valid_o high in cycle T+1.
- WAIT_CORE:
  - Watchdog increments every cycle.
  - core_ready_i=1: go to CAPTURE.
  - timeout_cycles_i!=0 and watchdog==timeout_cycles_i-1 without core_ready_i: set timeout_o, go to FINISH.
  - core_ready_i and watchdog expiry in the same cycle: core_ready_i wins.
- CAPTURE:
  - Drive sample_o=1 for exactly one cycle, which is the cycle after core_ready_i.
  - Increment step_count_o.
  - If the new count equals the latched n_steps, go to FINISH; otherwise go to ISSUE.
- FINISH: done_o=1 for one cycle, then go to IDLE.
- busy_o=1 in every state except IDLE.
- step_count_o holds its final value after the run and wraps modulo 2^STEP_W (unreachable, since the count is bounded by n_steps).
- start_i while busy_o=1 is ignored.
- abort_i has priority over every transition:
  - next state is IDLE and all pulse outputs are 0;
  - no done_o and no sample_o are generated;
  - step_count_o and timeout_o are preserved.
- Simultaneous start_i and abort_i in IDLE: abort wins and the start is dropped.
- core_ready_i outside WAIT_CORE is ignored.
- Mid-run reset returns to the reset values in the next cycle.
- All outputs are registered (no combinational path from input to output).

Decomposition:
- Package spiker_seq_pkg holds:
  - the state enum seq_state_e (IDLE, ISSUE, WAIT_CORE, CAPTURE, FINISH);
  - localparams for default widths.
- One natural sub-module: spiker_step_watchdog, a loadable TMO_W counter with clear/enable and a one-cycle expire pulse, disabled when the limit is 0.
- The FSM and step counter stay in the top module.

Test Plan:
- Basic run: n_steps=3, writer_ready_i=1, core replies 4 cycles after each core_valid_o -> three core_valid_o pulses, three sample_o pulses each one cycle after core_ready_i, done_o once, step_count_o=3, busy_o low afterwards.
- Zero steps: start_i with n_steps=0 -> done_o pulses the next cycle, no core_valid_o, busy_o stays 0.
- Writer backpressure: writer_ready_i=0 for 10 cycles after start -> core_valid_o held low, then fires one cycle after writer_ready_i rises.
- Watchdog: timeout_cycles=5 with no core_ready_i -> timeout_o=1 five cycles after core_valid_o, done_o pulses, step_count_o=0; next start clears timeout_o.
- Abort: abort_i in WAIT_CORE of step 2 of 4 -> IDLE next cycle, no done_o, step_count_o=1, a late core_ready_i gives no sample_o.
- Collisions:
  - start_i during a run -> ignored.
  - start_i with abort_i in IDLE -> no run begins.
  - core_ready_i on the same cycle as watchdog expiry -> step completes normally, timeout_o stays 0.
